// File: rtl/renkon_linebuf_window_pkg.sv
// Shared defaults, FSM state encoding and bank-selection helper for the renkon line-buffer window generator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package renkon_pkg;

  localparam int DWIDTH_DEFAULT  = 16;
  localparam int BUFSIZE_DEFAULT = 8;
  localparam int FSIZE_DEFAULT   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Bank holding window row k (0 = oldest) when the newest row lives in bank wptr.
  // Row r-(fsize-1-k) was written to bank (wptr - (fsize-1-k)) mod fsize, which is
  // the same bank as (wptr + k + 1) mod fsize.
  function automatic int bank_of_row(input int wptr, input int k, input int fsize);
    return (wptr + k + 1) % fsize;
  endfunction

endpackage

// File: rtl/renkon_linebuf_bank.sv
// One line-buffer bank: single-port RAM, synchronous write, registered-address read.
// Latency: read data valid one cycle after an enabled address.
// Backpressure: none; caller enables the address register only on accepted pixels.
// Ports: clk/xrst clock and async active-low reset (address register only);
//        i_we write strobe, i_en address-register enable, i_addr column address,
//        i_wdata write pixel, o_rdata pixel at the last registered address.
module renkon_linebuf_bank #(
  parameter int DWIDTH  = 16,
  parameter int BUFSIZE = 8
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               i_we,
  input  logic               i_en,
  input  logic [BUFSIZE-1:0] i_addr,
  input  logic [DWIDTH-1:0]  i_wdata,
  output logic [DWIDTH-1:0]  o_rdata
);

  logic [DWIDTH-1:0]  r_mem [2**BUFSIZE];
  logic [BUFSIZE-1:0] r_addr;

  // Storage is never reset; stale rows are kept out of valid windows by the row counter.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_addr <= '0;
    end else if (i_en) begin
      r_addr <= i_addr;
    end
  end

  assign o_rdata = r_mem[r_addr];

endmodule

// File: rtl/renkon_linebuf_window.sv
// Streaming FSIZE x FSIZE window generator over a ring of FSIZE line-buffer banks, raster-order input.
// Latency: window for a pixel accepted in cycle t appears in cycle t+2 (t+3 with RENKON_LINEBUF_OUTREG_EN).
// Backpressure: none; in_valid gaps propagate as out_valid gaps.
// Ports: clk, xrst (async active-low); buf_start/img_size start an image from IDLE;
//        in_valid/buf_input pixel stream; out_valid/out_window window output, element [i][j]
//        at bits (i*FSIZE+j)*DWIDTH, i=0 oldest row, j=0 leftmost; buf_done end-of-image pulse.
// Option macro: RENKON_LINEBUF_OUTREG_EN adds an output register stage and one drain cycle.
module renkon_linebuf_window
  import renkon_pkg::*;
#(
  parameter int DWIDTH  = DWIDTH_DEFAULT,
  parameter int BUFSIZE = BUFSIZE_DEFAULT,
  parameter int FSIZE   = FSIZE_DEFAULT
) (
  input  logic                            clk,
  input  logic                            xrst,
  input  logic                            buf_start,
  input  logic [BUFSIZE-1:0]              img_size,
  input  logic                            in_valid,
  input  logic [DWIDTH-1:0]               buf_input,
  output logic                            out_valid,
  output logic [FSIZE*FSIZE*DWIDTH-1:0]   out_window,
  output logic                            buf_done
);

  localparam int WPW = (FSIZE > 1) ? $clog2(FSIZE) : 1;
`ifdef RENKON_LINEBUF_OUTREG_EN
  localparam int DRAIN_CYC = 3;
`else
  localparam int DRAIN_CYC = 2;
`endif
  localparam logic [BUFSIZE-1:0] LP_FM1  = BUFSIZE'(FSIZE - 1);
  localparam logic [WPW-1:0]     LP_WMAX = WPW'(FSIZE - 1);
  localparam logic [1:0]         LP_DEND = 2'(DRAIN_CYC - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BUFSIZE-1:0] r_last_idx;
  logic [BUFSIZE-1:0] r_col;
  logic [BUFSIZE-1:0] r_row;
  logic [WPW-1:0]     r_wptr;
  logic [1:0]         r_drain;

  logic w_start;
  logic w_accept;
  logic w_col_last;
  logic w_row_last;

  assign w_start    = (r_state == ST_IDLE) && buf_start && (img_size != '0);
  assign w_accept   = (r_state == ST_RUN) && in_valid;
  assign w_col_last = (r_col == r_last_idx);
  assign w_row_last = (r_row == r_last_idx);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_accept && w_col_last && w_row_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_drain == LP_DEND) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- position counters and bank write pointer ----------------
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_last_idx <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_wptr     <= '0;
      r_drain    <= '0;
    end else begin
      r_drain <= (r_state == ST_DRAIN) ? r_drain + 2'd1 : 2'd0;
      if (w_start) begin
        r_last_idx <= img_size - BUFSIZE'(1);
        r_col      <= '0;
        r_row      <= '0;
        r_wptr     <= '0;
      end else if (w_accept) begin
        if (w_col_last) begin
          r_col  <= '0;
          r_row  <= r_row + BUFSIZE'(1);
          r_wptr <= (r_wptr == LP_WMAX) ? '0 : r_wptr + WPW'(1);
        end else begin
          r_col <= r_col + BUFSIZE'(1);
        end
      end
    end
  end

  // ---------------- line-buffer banks ----------------
  logic [DWIDTH-1:0] w_bank_q [FSIZE];

  for (genvar b = 0; b < FSIZE; b++) begin : g_bank
    logic w_we;
    assign w_we = w_accept && (r_wptr == WPW'(b));
    renkon_linebuf_bank #(
      .DWIDTH  (DWIDTH),
      .BUFSIZE (BUFSIZE)
    ) u_bank (
      .clk     (clk),
      .xrst    (xrst),
      .i_we    (w_we),
      .i_en    (w_accept),
      .i_addr  (r_col),
      .i_wdata (buf_input),
      .o_rdata (w_bank_q[b])
    );
  end

  // ---------------- stage 1: column assembly ----------------
  logic              r_s1_vld;
  logic              r_s1_ok;
  logic              r_s1_last;
  logic [DWIDTH-1:0] r_s1_pix;
  logic [WPW-1:0]    r_s1_wptr;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_s1_vld  <= 1'b0;
      r_s1_ok   <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_pix  <= '0;
      r_s1_wptr <= '0;
    end else begin
      r_s1_vld  <= w_accept;
      // Only positions with FSIZE complete rows above-and-including and FSIZE
      // columns to the left in this row produce a window; this also keeps stale
      // bank contents and row-wrap columns out of every valid window.
      r_s1_ok   <= w_accept && (r_row >= LP_FM1) && (r_col >= LP_FM1);
      r_s1_last <= w_accept && w_col_last && w_row_last;
      if (w_accept) begin
        r_s1_pix  <= buf_input;
        r_s1_wptr <= r_wptr;
      end
    end
  end

  // Newest row comes from the registered pixel, older rows from the banks,
  // rotated so index 0 is the oldest row.
  logic [FSIZE-1:0][DWIDTH-1:0] w_col;

  for (genvar k = 0; k < FSIZE - 1; k++) begin : g_col
    logic [WPW-1:0] w_sel;
    assign w_sel    = WPW'(bank_of_row(int'(r_s1_wptr), k, FSIZE));
    assign w_col[k] = w_bank_q[w_sel];
  end
  assign w_col[FSIZE-1] = r_s1_pix;

  // ---------------- stage 2: window shift register ----------------
  logic [FSIZE-1:0][FSIZE-1:0][DWIDTH-1:0] r_win;
  logic                                    r_vld;
  logic                                    r_done;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_win  <= '0;
      r_vld  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_vld  <= r_s1_vld && r_s1_ok;
      r_done <= r_s1_last;
      if (r_s1_vld) begin
        for (int i = 0; i < FSIZE; i++) begin
          for (int j = 0; j < FSIZE - 1; j++) begin
            r_win[i][j] <= r_win[i][j+1];
          end
          r_win[i][FSIZE-1] <= w_col[i];
        end
      end
    end
  end

`ifdef RENKON_LINEBUF_OUTREG_EN
  logic [FSIZE*FSIZE*DWIDTH-1:0] r_o_win;
  logic                          r_o_vld;
  logic                          r_o_done;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_o_win  <= '0;
      r_o_vld  <= 1'b0;
      r_o_done <= 1'b0;
    end else begin
      r_o_win  <= r_win;
      r_o_vld  <= r_vld;
      r_o_done <= r_done;
    end
  end

  assign out_window = r_o_win;
  assign out_valid  = r_o_vld;
  assign buf_done   = r_o_done;
`else
  assign out_window = r_win;
  assign out_valid  = r_vld;
  assign buf_done   = r_done;
`endif

endmodule

// File: tb/tb_renkon_linebuf_window.sv
// Self-checking bench for renkon_linebuf_window (FSIZE=3): reference windows computed from a stored image.
// Latency: expects outputs 2 cycles after acceptance (3 with RENKON_LINEBUF_OUTREG_EN).
// Backpressure: none exercised; input gaps drive output gaps.
module tb_renkon_linebuf_window;

  localparam int DW = 16;
  localparam int BS = 8;
  localparam int F  = 3;
  localparam int WW = F * F * DW;
  localparam int NC = 1024;
`ifdef RENKON_LINEBUF_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          xrst;
  logic          buf_start;
  logic [BS-1:0] img_size;
  logic          in_valid;
  logic [DW-1:0] buf_input;
  logic          out_valid;
  logic [WW-1:0] out_window;
  logic          buf_done;

  always #5 clk = ~clk;

  renkon_linebuf_window #(
    .DWIDTH  (DW),
    .BUFSIZE (BS),
    .FSIZE   (F)
  ) dut (
    .clk        (clk),
    .xrst       (xrst),
    .buf_start  (buf_start),
    .img_size   (img_size),
    .in_valid   (in_valid),
    .buf_input  (buf_input),
    .out_valid  (out_valid),
    .out_window (out_window),
    .buf_done   (buf_done)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] img [0:15][0:15];
  int            acc_cyc [0:255];
  bit            exp_vld  [0:NC-1];
  bit            exp_done [0:NC-1];
  logic [WW-1:0] exp_win  [0:NC-1];
  logic          obs_vld  [0:NC-1];
  logic          obs_done [0:NC-1];
  logic [WW-1:0] obs_win  [0:NC-1];
  int            ncyc;

  // Drives one image (cycle 0 = buf_start cycle), records outputs per cycle,
  // then derives expected outputs from the stored image and acceptance cycles.
  // gap_mode: 0 continuous, 1 every other cycle, 2 random.
  task automatic run_image(input int size, input int base, input int gap_mode,
                           input bit rnd_pix, input bit poke_start);
    int  n;
    int  npix;
    int  k;
    int  r;
    int  c;
    int  t;
    bit  v;
    n    = 0;
    npix = size * size;
    for (int i = 0; i < NC; i++) begin
      exp_vld[i] = 0; exp_done[i] = 0; exp_win[i] = '0;
      obs_vld[i] = 0; obs_done[i] = 0; obs_win[i] = '0;
    end
    k = 0;
    obs_vld[0] = out_valid; obs_done[0] = buf_done; obs_win[0] = out_window;
    buf_start = 1'b1;
    img_size  = BS'(size);
    in_valid  = 1'b0;
    @(posedge clk); #1;
    k = 1;
    buf_start = 1'b0;
    while (1) begin
      obs_vld[k] = out_valid; obs_done[k] = buf_done; obs_win[k] = out_window;
      if (n < npix) begin
        case (gap_mode)
          0:       v = 1'b1;
          1:       v = (k % 2 == 1);
          default: v = ($urandom_range(0, 1) == 1);
        endcase
        buf_start = poke_start && (k == 4);
        if (buf_start) img_size = BS'($urandom_range(1, 9));
        if (v) begin
          r = n / size;
          c = n % size;
          img[r][c]  = rnd_pix ? DW'($urandom) : DW'(base + r * 16 + c);
          buf_input  = img[r][c];
          acc_cyc[n] = k;
          n++;
        end else begin
          buf_input = DW'($urandom);
        end
        in_valid = v;
      end else begin
        in_valid  = 1'b0;
        buf_start = 1'b0;
      end
      if (n == npix && k >= acc_cyc[npix-1] + LAT + 1) break;
      if (k >= NC - 2) begin
        total++; bad++;
        $display("FAIL run_image cycle budget reached at %0d, pixels sent %0d of %0d", k, n, npix);
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    in_valid  = 1'b0;
    buf_start = 1'b0;
    ncyc = k + 1;
    @(posedge clk); #1;
    for (int p = 0; p < npix; p++) begin
      r = p / size;
      c = p % size;
      t = acc_cyc[p] + LAT;
      if (r >= F - 1 && c >= F - 1) begin
        exp_vld[t] = 1;
        for (int i = 0; i < F; i++)
          for (int j = 0; j < F; j++)
            exp_win[t][(i * F + j) * DW +: DW] = img[r - F + 1 + i][c - F + 1 + j];
      end
      if (p == npix - 1) exp_done[t] = 1;
    end
  endtask

  task automatic test_reset();
    int seen;
    xrst = 1'b0; buf_start = 1'b0; img_size = '0; in_valid = 1'b0; buf_input = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", out_valid); end
    total++; if (buf_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", buf_done); end
    total++; if (out_window !== '0) begin bad++; $display("FAIL reset_win got=%h want=0", out_window); end
    xrst = 1'b1;
    @(posedge clk); #1;
    // in_valid in IDLE and a zero-size start must both be ignored
    seen = 0;
    for (int k = 0; k < 24; k++) begin
      buf_start = (k == 2);
      img_size  = '0;
      in_valid  = 1'b1;
      buf_input = DW'($urandom);
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || buf_done !== 1'b0) seen++;
    end
    in_valid = 1'b0; buf_start = 1'b0;
    total++; if (seen != 0) begin bad++; $display("FAIL idle_ignore active_cycles got=%0d want=0", seen); end
  endtask

  task automatic test_basic();
    int nwin;
    int first;
    logic [WW-1:0] w0;
    run_image(4, 0, 0, 0, 0);
    nwin = 0; first = -1;
    for (int k = 0; k < ncyc; k++) begin
      total++;
      if (obs_vld[k] !== exp_vld[k] || obs_done[k] !== exp_done[k] || (exp_vld[k] && obs_win[k] !== exp_win[k])) begin
        bad++;
        $display("FAIL basic cyc=%0d vld=%b want=%b done=%b want=%b win=%h want=%h", k, obs_vld[k], exp_vld[k], obs_done[k], exp_done[k], obs_win[k], exp_win[k]);
      end
      if (obs_vld[k] === 1'b1) begin
        nwin++;
        if (first < 0) first = k;
      end
    end
    total++; if (nwin != 4) begin bad++; $display("FAIL basic_count got=%0d want=4", nwin); end
    for (int i = 0; i < F; i++)
      for (int j = 0; j < F; j++)
        w0[(i * F + j) * DW +: DW] = DW'(i * 16 + j);
    total++;
    if (first != acc_cyc[10] + LAT) begin
      bad++; $display("FAIL basic_first_cycle got=%0d want=%0d", first, acc_cyc[10] + LAT);
    end else if (obs_win[first] !== w0) begin
      bad++; $display("FAIL basic_first_win got=%h want=%h", obs_win[first], w0);
    end
  endtask

  task automatic test_gaps();
    int nwin;
    run_image(4, 0, 1, 0, 0);
    nwin = 0;
    for (int k = 0; k < ncyc; k++) begin
      total++;
      if (obs_vld[k] !== exp_vld[k] || obs_done[k] !== exp_done[k] || (exp_vld[k] && obs_win[k] !== exp_win[k])) begin
        bad++;
        $display("FAIL gaps cyc=%0d vld=%b want=%b done=%b want=%b win=%h want=%h", k, obs_vld[k], exp_vld[k], obs_done[k], exp_done[k], obs_win[k], exp_win[k]);
      end
      if (obs_vld[k] === 1'b1) nwin++;
    end
    total++; if (nwin != 4) begin bad++; $display("FAIL gaps_count got=%0d want=4", nwin); end
  endtask

  task automatic test_small();
    int nwin;
    int ndone;
    run_image(2, 0, 0, 0, 0);
    nwin = 0; ndone = 0;
    for (int k = 0; k < ncyc; k++) begin
      total++;
      if (obs_vld[k] !== exp_vld[k] || obs_done[k] !== exp_done[k]) begin
        bad++;
        $display("FAIL small cyc=%0d vld=%b want=%b done=%b want=%b", k, obs_vld[k], exp_vld[k], obs_done[k], exp_done[k]);
      end
      if (obs_vld[k] === 1'b1) nwin++;
      if (obs_done[k] === 1'b1) ndone++;
    end
    total++; if (nwin != 0) begin bad++; $display("FAIL small_count got=%0d want=0", nwin); end
    total++; if (ndone != 1) begin bad++; $display("FAIL small_done_pulses got=%0d want=1", ndone); end
  endtask

  task automatic test_back_to_back();
    run_image(4, 0, 0, 0, 0);
    for (int k = 0; k < ncyc; k++) begin
      total++;
      if (obs_vld[k] !== exp_vld[k] || obs_done[k] !== exp_done[k] || (exp_vld[k] && obs_win[k] !== exp_win[k])) begin
        bad++;
        $display("FAIL b2b_first cyc=%0d vld=%b want=%b done=%b want=%b win=%h want=%h", k, obs_vld[k], exp_vld[k], obs_done[k], exp_done[k], obs_win[k], exp_win[k]);
      end
    end
    run_image(4, 'h80, 0, 0, 1);
    for (int k = 0; k < ncyc; k++) begin
      total++;
      if (obs_vld[k] !== exp_vld[k] || obs_done[k] !== exp_done[k] || (exp_vld[k] && obs_win[k] !== exp_win[k])) begin
        bad++;
        $display("FAIL b2b_second cyc=%0d vld=%b want=%b done=%b want=%b win=%h want=%h", k, obs_vld[k], exp_vld[k], obs_done[k], exp_done[k], obs_win[k], exp_win[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    buf_start = 1'b1; img_size = BS'(4); in_valid = 1'b0;
    @(posedge clk); #1;
    buf_start = 1'b0;
    for (int p = 0; p < 6; p++) begin
      in_valid  = 1'b1;
      buf_input = DW'(16'h0100 + (p / 4) * 16 + (p % 4));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    xrst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_vld got=%b want=0", out_valid); end
    total++; if (buf_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", buf_done); end
    total++; if (out_window !== '0) begin bad++; $display("FAIL midrst_win got=%h want=0", out_window); end
    @(posedge clk); #1;
    xrst = 1'b1;
    // Without a new buf_start the block must stay idle.
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      in_valid  = 1'b1;
      buf_input = DW'($urandom);
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || buf_done !== 1'b0) seen++;
    end
    in_valid = 1'b0;
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_idle active_cycles got=%0d want=0", seen); end
    run_image(4, 'h40, 0, 0, 0);
    for (int k = 0; k < ncyc; k++) begin
      total++;
      if (obs_vld[k] !== exp_vld[k] || obs_done[k] !== exp_done[k] || (exp_vld[k] && obs_win[k] !== exp_win[k])) begin
        bad++;
        $display("FAIL midrst_fresh cyc=%0d vld=%b want=%b done=%b want=%b win=%h want=%h", k, obs_vld[k], exp_vld[k], obs_done[k], exp_done[k], obs_win[k], exp_win[k]);
      end
    end
  endtask

  task automatic test_random();
    int sz;
    for (int it = 0; it < 4; it++) begin
      sz = $urandom_range(3, 11);
      run_image(sz, 0, 2, 1, 0);
      for (int k = 0; k < ncyc; k++) begin
        total++;
        if (obs_vld[k] !== exp_vld[k] || obs_done[k] !== exp_done[k] || (exp_vld[k] && obs_win[k] !== exp_win[k])) begin
          bad++;
          $display("FAIL random it=%0d size=%0d cyc=%0d vld=%b want=%b done=%b want=%b win=%h want=%h", it, sz, k, obs_vld[k], exp_vld[k], obs_done[k], exp_done[k], obs_win[k], exp_win[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_small();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
